// File: rtl/sdram_arbiter.sv
// Three-master arbiter in front of the SDRAM controller: strict-priority master with a
// consecutive-grant cap, round-robin for the rest, one request in flight, registered read return.
module sdram_arbiter #(
  parameter int PRIO_MASTER = 2,
  parameter int MAX_CONSEC  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  m_req,
  input  logic [77:0] m_addr,
  input  logic [2:0]  m_write,
  input  logic [11:0] m_byte_enable,
  input  logic [95:0] m_wdata,
  output logic [2:0]  m_ack,
  output logic [31:0] m_rdata,
  output logic [2:0]  m_rdvalid,
  output logic [2:0]  sdram_req,
  output logic [25:0] sdram_addr,
  output logic        sdram_write,
  output logic [3:0]  sdram_byte_enable,
  output logic [31:0] sdram_wdata,
  input  logic        sdram_ack,
  input  logic [31:0] sdram_rdata,
  input  logic [2:0]  sdram_rdvalid,
  output logic        ack_timeout
);

  localparam int CW = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0]    PRIO_MASK  = 3'(1 << PRIO_MASTER);
  localparam logic [1:0]    PRIO_IDX   = 2'(PRIO_MASTER);
  localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_CONSEC);
  localparam logic [TW-1:0] TMO_LIM    = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_reg, state_next;
  logic [2:0]    grant_reg, grant_next;
  logic [1:0]    rr_reg, rr_next;
  logic [CW-1:0] consec_reg, consec_next;
  logic [TW-1:0] tmo_cnt_reg;
  logic          ack_timeout_reg;
  logic [25:0]   addr_reg;
  logic          write_reg;
  logic [3:0]    be_reg;
  logic [31:0]   wdata_reg;
  logic [2:0]    rdvalid_reg;
  logic [31:0]   rdata_reg;

  logic [2:0]    eligible;
  logic          prio_elig, others_elig, prio_win, rr_found, load;
  logic [1:0]    rr_idx, cand, win_idx;
  logic [25:0]   win_addr;
  logic          win_write;
  logic [3:0]    win_be;
  logic [31:0]   win_wdata;

  function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      rr_reg          <= '0;
      consec_reg      <= '0;
      tmo_cnt_reg     <= '0;
      ack_timeout_reg <= 1'b0;
      addr_reg        <= '0;
      write_reg       <= 1'b0;
      be_reg          <= '0;
      wdata_reg       <= '0;
      rdvalid_reg     <= '0;
      rdata_reg       <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_reg     <= rr_next;
      consec_reg <= consec_next;
      if (load) begin
        addr_reg    <= win_addr;
        write_reg   <= win_write;
        be_reg      <= win_be;
        wdata_reg   <= win_wdata;
        tmo_cnt_reg <= '0;
      end else if (state_reg == BUSY && !sdram_ack && tmo_cnt_reg != TMO_LIM) begin
        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        if (tmo_cnt_reg == TMO_LAST) ack_timeout_reg <= 1'b1;
      end
      // Read return is a plain pipeline stage, independent of the request path.
      rdvalid_reg <= sdram_rdvalid;
      rdata_reg   <= sdram_rdata;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_next     = rr_reg;
    consec_next = consec_reg;
    load        = 1'b0;
    // The acked master still shows m_req this cycle, so it must not win again.
    eligible    = m_req & ~(((state_reg == BUSY) && sdram_ack) ? grant_reg : 3'b000);
    prio_elig   = |(eligible & PRIO_MASK);
    others_elig = |(eligible & ~PRIO_MASK);
    prio_win    = prio_elig && ((consec_reg < CONSEC_MAX) || !others_elig);
    rr_idx      = rr_reg;
    rr_found    = 1'b0;
    cand        = rr_reg;
    for (int k = 0; k < 3; k++) begin
      cand = wrap_add(rr_reg, 2'(k));
      if (!rr_found && eligible[cand]) begin
        rr_idx   = cand;
        rr_found = 1'b1;
      end
    end
    win_idx = prio_win ? PRIO_IDX : rr_idx;
    if ((state_reg == IDLE) || sdram_ack) begin
      if (|eligible) begin
        state_next = BUSY;
        grant_next = 3'b001 << win_idx;
        load       = 1'b1;
        if (prio_win) begin
          consec_next = others_elig ? consec_reg + CW'(1) : '0;
        end else begin
          rr_next     = (rr_idx == 2'd2) ? 2'd0 : rr_idx + 2'd1;
          consec_next = '0;
        end
      end else begin
        state_next = IDLE;
        grant_next = '0;
      end
    end
  end

  always_comb begin
    case (win_idx)
      2'd1: begin
        win_addr  = m_addr[51:26];
        win_write = m_write[1];
        win_be    = m_byte_enable[7:4];
        win_wdata = m_wdata[63:32];
      end
      2'd2: begin
        win_addr  = m_addr[77:52];
        win_write = m_write[2];
        win_be    = m_byte_enable[11:8];
        win_wdata = m_wdata[95:64];
      end
      default: begin
        win_addr  = m_addr[25:0];
        win_write = m_write[0];
        win_be    = m_byte_enable[3:0];
        win_wdata = m_wdata[31:0];
      end
    endcase
  end

  always_comb begin
    sdram_req = (state_reg == BUSY) ? grant_reg : 3'b000;
    m_ack     = sdram_ack ? sdram_req : 3'b000;
  end

  assign sdram_addr        = addr_reg;
  assign sdram_write       = write_reg;
  assign sdram_byte_enable = be_reg;
  assign sdram_wdata       = wdata_reg;
  assign m_rdvalid         = rdvalid_reg;
  assign m_rdata           = rdata_reg;
  assign ack_timeout       = ack_timeout_reg;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against an abstract arbitration model.
module tb_sdram_arbiter;
  localparam int PRIO = 2;
  localparam int MAXC = 4;
  localparam int TMO  = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  m_req;
  logic [25:0] addr_v [3];
  logic [2:0]  m_write;
  logic [3:0]  be_v [3];
  logic [31:0] wd_v [3];
  logic [77:0] m_addr;
  logic [11:0] m_byte_enable;
  logic [95:0] m_wdata;
  logic [2:0]  m_ack;
  logic [31:0] m_rdata;
  logic [2:0]  m_rdvalid;
  logic [2:0]  sdram_req;
  logic [25:0] sdram_addr;
  logic        sdram_write;
  logic [3:0]  sdram_byte_enable;
  logic [31:0] sdram_wdata;
  logic        sdram_ack;
  logic [31:0] sdram_rdata;
  logic [2:0]  sdram_rdvalid;
  logic        ack_timeout;

  assign m_addr        = {addr_v[2], addr_v[1], addr_v[0]};
  assign m_byte_enable = {be_v[2], be_v[1], be_v[0]};
  assign m_wdata       = {wd_v[2], wd_v[1], wd_v[0]};

  always #5 clock = ~clock;

  sdram_arbiter #(.PRIO_MASTER(PRIO), .MAX_CONSEC(MAXC), .ACK_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .m_req(m_req), .m_addr(m_addr), .m_write(m_write),
    .m_byte_enable(m_byte_enable), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_rdvalid(m_rdvalid),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_write(sdram_write),
    .sdram_byte_enable(sdram_byte_enable), .sdram_wdata(sdram_wdata),
    .sdram_ack(sdram_ack), .sdram_rdata(sdram_rdata), .sdram_rdvalid(sdram_rdvalid),
    .ack_timeout(ack_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which master owns the controller, plus fairness bookkeeping.
  bit          md_busy;
  int          md_grant, md_rr, md_consec, md_tcnt;
  bit          md_tmo;
  logic [25:0] md_addr;
  logic        md_write;
  logic [3:0]  md_be;
  logic [31:0] md_wd;
  logic [2:0]  md_rdv;
  logic [31:0] md_rdata;

  task automatic model_reset();
    md_busy = 0; md_grant = 0; md_rr = 0; md_consec = 0; md_tcnt = 0; md_tmo = 0;
    md_addr = '0; md_write = 0; md_be = '0; md_wd = '0; md_rdv = '0; md_rdata = '0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven, then advance the DUT.
  task automatic tick();
    bit [2:0] elig;
    bit       others;
    int       win;
    if (!md_busy || sdram_ack) begin
      others = 0;
      win    = -1;
      for (int i = 0; i < 3; i++) begin
        elig[i] = m_req[i] && !(md_busy && sdram_ack && md_grant == i);
        if (elig[i] && i != PRIO) others = 1;
      end
      if (elig == 3'b000) begin
        md_busy = 0;
      end else begin
        if (PRIO < 3 && elig[PRIO] && (md_consec < MAXC || !others)) begin
          win = PRIO;
          md_consec = others ? md_consec + 1 : 0;
        end else begin
          for (int k = 0; k < 3; k++) begin
            int j = (md_rr + k) % 3;
            if (win < 0 && elig[j]) win = j;
          end
          md_rr = (win + 1) % 3;
          md_consec = 0;
        end
        md_busy = 1; md_grant = win; md_tcnt = 0;
        md_addr = addr_v[win]; md_write = m_write[win]; md_be = be_v[win]; md_wd = wd_v[win];
        $display("[%0t] grant m%0d addr=%h we=%b be=%b wd=%h", $time, win, md_addr, md_write, md_be, md_wd);
      end
    end else begin
      if (md_tcnt < TMO) md_tcnt++;
      if (md_tcnt == TMO) md_tmo = 1;
    end
    md_rdv = sdram_rdvalid;
    md_rdata = sdram_rdata;
    @(posedge clock);
    #1;
  endtask

  task automatic new_req(input int i);
    m_req[i]   = 1'b1;
    addr_v[i]  = 26'($urandom);
    m_write[i] = 1'($urandom);
    be_v[i]    = 4'($urandom);
    wd_v[i]    = $urandom;
  endtask

  task automatic drain();
    int guard = 0;
    for (int i = 0; i < 3; i++) if (!(md_busy && md_grant == i)) m_req[i] = 1'b0;
    sdram_ack = 1'b1;
    sdram_rdvalid = 3'b000;
    while (md_busy && guard < 10) begin
      tick();
      m_req = 3'b000;
      guard++;
    end
    m_req = 3'b000;
    sdram_ack = 1'b0;
    n_cmp++;
    if (sdram_req !== 3'b000) begin
      n_bad++; $display("FAIL drain_idle: sdram_req=%b required 000", sdram_req);
    end
  endtask

  task automatic test_reset();
    sdram_ack = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (sdram_req !== 3'b000) begin n_bad++; $display("FAIL rst_req: got %b required 000", sdram_req); end
    n_cmp++; if (sdram_addr !== 26'h0) begin n_bad++; $display("FAIL rst_addr: got %h required 0", sdram_addr); end
    n_cmp++; if (sdram_wdata !== 32'h0 || sdram_write !== 1'b0 || sdram_byte_enable !== 4'h0) begin
      n_bad++; $display("FAIL rst_fields: wd=%h we=%b be=%b required zeros", sdram_wdata, sdram_write, sdram_byte_enable);
    end
    n_cmp++; if (m_rdvalid !== 3'b000 || m_rdata !== 32'h0) begin
      n_bad++; $display("FAIL rst_rd: rdvalid=%b rdata=%h required zeros", m_rdvalid, m_rdata);
    end
    n_cmp++; if (ack_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_tmo: got %b required 0", ack_timeout); end
    n_cmp++; if (m_ack !== 3'b000) begin n_bad++; $display("FAIL rst_mack: got %b required 000", m_ack); end
    sdram_ack = 1'b0;
    reset = 1'b1;
    model_reset();
    $display("[%0t] reset released", $time);
  endtask

  task automatic test_single_read();
    m_req = 3'b010; addr_v[1] = 26'h0000100; m_write[1] = 1'b0; be_v[1] = 4'hF; wd_v[1] = 32'h0;
    #1;
    n_cmp++; if (m_ack !== 3'b000) begin n_bad++; $display("FAIL rd_idle_ack: got %b required 000", m_ack); end
    tick();
    n_cmp++; if (sdram_req !== 3'b010) begin n_bad++; $display("FAIL rd_req: got %b required 010", sdram_req); end
    n_cmp++; if (sdram_addr !== 26'h0000100 || sdram_write !== 1'b0) begin
      n_bad++; $display("FAIL rd_addr: addr=%h we=%b required 0000100/0", sdram_addr, sdram_write);
    end
    tick();
    n_cmp++; if (sdram_req !== 3'b010) begin n_bad++; $display("FAIL rd_hold: got %b required 010", sdram_req); end
    sdram_ack = 1'b1;
    #1;
    n_cmp++; if (m_ack !== 3'b010) begin n_bad++; $display("FAIL rd_mack: got %b required 010", m_ack); end
    tick();
    m_req = 3'b000; sdram_ack = 1'b0; sdram_rdvalid = 3'b010; sdram_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (sdram_req !== 3'b000) begin n_bad++; $display("FAIL rd_after_ack: got %b required 000", sdram_req); end
    n_cmp++; if (m_rdvalid !== 3'b000) begin n_bad++; $display("FAIL rd_early: got %b required 000", m_rdvalid); end
    tick();
    n_cmp++; if (m_rdvalid !== 3'b010 || m_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL rd_return: rdvalid=%b rdata=%h required 010/deadbeef", m_rdvalid, m_rdata);
    end
    sdram_rdvalid = 3'b000;
    sdram_ack = 1'b1;
    #1;
    n_cmp++; if (m_ack !== 3'b000) begin n_bad++; $display("FAIL idle_ack_ignored: got %b required 000", m_ack); end
    tick();
    sdram_ack = 1'b0;
    n_cmp++; if (sdram_req !== 3'b000 || m_rdvalid !== 3'b000) begin
      n_bad++; $display("FAIL rd_quiet: req=%b rdvalid=%b required 000/000", sdram_req, m_rdvalid);
    end
  endtask

  task automatic test_write();
    m_req = 3'b001; addr_v[0] = 26'h2ABCDEF; m_write[0] = 1'b1; be_v[0] = 4'b0011; wd_v[0] = 32'h12345678;
    tick();
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (sdram_req !== 3'b001 || sdram_write !== 1'b1 || sdram_byte_enable !== 4'b0011 ||
          sdram_wdata !== 32'h12345678 || sdram_addr !== 26'h2ABCDEF) begin
        n_bad++;
        $display("FAIL wr_fields: req=%b we=%b be=%b wd=%h addr=%h required 001/1/0011/12345678/2abcdef",
                 sdram_req, sdram_write, sdram_byte_enable, sdram_wdata, sdram_addr);
      end
      tick();
    end
    sdram_ack = 1'b1;
    #1;
    n_cmp++; if (m_ack !== 3'b001) begin n_bad++; $display("FAIL wr_mack: got %b required 001", m_ack); end
    tick();
    m_req = 3'b000; sdram_ack = 1'b0;
    repeat (2) tick();
    n_cmp++; if (m_rdvalid !== 3'b000) begin n_bad++; $display("FAIL wr_no_rdvalid: got %b required 000", m_rdvalid); end
  endtask

  task automatic test_alternate();
    int exp;
    m_req = 3'b011;
    addr_v[0] = 26'h0000AAA; m_write[0] = 1'b0;
    addr_v[1] = 26'h0000BBB; m_write[1] = 1'b0;
    tick();
    exp = md_grant;
    n_cmp++; if (sdram_req !== 3'(1 << exp)) begin n_bad++; $display("FAIL alt_first: got %b required %b", sdram_req, 3'(1 << exp)); end
    sdram_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp = 1 - exp;
      n_cmp++;
      if (sdram_req !== 3'(1 << exp) || sdram_addr !== addr_v[exp]) begin
        n_bad++; $display("FAIL alt_order: req=%b addr=%h required %b/%h", sdram_req, sdram_addr, 3'(1 << exp), addr_v[exp]);
      end
    end
    drain();
  endtask

  task automatic test_prio();
    m_req = 3'b001; addr_v[0] = 26'h0000C00; m_write[0] = 1'b0;
    tick();
    m_req = 3'b111; addr_v[1] = 26'h0000C11; addr_v[2] = 26'h0000C22; m_write[1] = 1'b0; m_write[2] = 1'b0;
    sdram_ack = 1'b1;
    tick();
    n_cmp++; if (sdram_req !== 3'b100 || sdram_addr !== 26'h0000C22) begin
      n_bad++; $display("FAIL prio_win: req=%b addr=%h required 100/0000c22", sdram_req, sdram_addr);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (sdram_req !== (md_busy ? 3'(1 << md_grant) : 3'b000)) begin
        n_bad++; $display("FAIL prio_seq: got %b required %b", sdram_req, md_busy ? 3'(1 << md_grant) : 3'b000);
      end
    end
    drain();
  endtask

  task automatic test_random();
    int       acked;
    int       r;
    logic [2:0] exp_req;
    m_req = 3'b000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      sdram_ack = md_busy ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 5);
      sdram_rdvalid = (r < 3) ? 3'(1 << r) : 3'b000;
      sdram_rdata = $urandom;
      #1;
      exp_req = md_busy ? 3'(1 << md_grant) : 3'b000;
      n_cmp++;
      if (m_ack !== (sdram_ack ? exp_req : 3'b000)) begin
        n_bad++; $display("FAIL rnd_mack c%0d: got %b required %b", cyc, m_ack, sdram_ack ? exp_req : 3'b000);
      end
      n_cmp++;
      if (sdram_req !== exp_req) begin
        n_bad++; $display("FAIL rnd_req c%0d: got %b required %b", cyc, sdram_req, exp_req);
      end
      if (md_busy) begin
        n_cmp++;
        if (sdram_addr !== md_addr || sdram_write !== md_write || sdram_byte_enable !== md_be || sdram_wdata !== md_wd) begin
          n_bad++; $display("FAIL rnd_fields c%0d: got %h/%b/%b/%h required %h/%b/%b/%h", cyc,
                            sdram_addr, sdram_write, sdram_byte_enable, sdram_wdata, md_addr, md_write, md_be, md_wd);
        end
      end
      n_cmp++;
      if (m_rdvalid !== md_rdv || m_rdata !== md_rdata || ack_timeout !== md_tmo) begin
        n_bad++; $display("FAIL rnd_rd c%0d: got %b/%h/%b required %b/%h/%b", cyc,
                          m_rdvalid, m_rdata, ack_timeout, md_rdv, md_rdata, md_tmo);
      end
      acked = (md_busy && sdram_ack) ? md_grant : -1;
      tick();
      for (int i = 0; i < 3; i++) begin
        if (i == acked) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else m_req[i] = 1'b0;
        end else if (!m_req[i] && $urandom_range(0, 3) == 0) begin
          new_req(i);
        end
      end
    end
    drain();
  endtask

  task automatic test_timeout();
    m_req = 3'b010; addr_v[1] = 26'h0000777; m_write[1] = 1'b0;
    tick();
    repeat (TMO - 1) tick();
    n_cmp++; if (ack_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got %b required 0", ack_timeout); end
    tick();
    n_cmp++; if (ack_timeout !== 1'b1 || sdram_req !== 3'b010) begin
      n_bad++; $display("FAIL tmo_set: tmo=%b req=%b required 1/010", ack_timeout, sdram_req);
    end
    sdram_ack = 1'b1;
    tick();
    m_req = 3'b000; sdram_ack = 1'b0;
    repeat (3) tick();
    n_cmp++; if (ack_timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b required 1", ack_timeout); end
  endtask

  task automatic test_reset_busy();
    m_req = 3'b011; addr_v[0] = 26'h0000123; addr_v[1] = 26'h0000456; m_write[0] = 1'b0; m_write[1] = 1'b0;
    sdram_rdvalid = 3'b100; sdram_rdata = 32'hCAFEF00D;
    tick();
    n_cmp++; if (sdram_req !== 3'(1 << md_grant) || m_rdvalid !== 3'b100) begin
      n_bad++; $display("FAIL rb_pre: req=%b rdvalid=%b required %b/100", sdram_req, m_rdvalid, 3'(1 << md_grant));
    end
    sdram_ack = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (sdram_req !== 3'b000 || m_ack !== 3'b000 || ack_timeout !== 1'b0) begin
      n_bad++; $display("FAIL rb_async: req=%b mack=%b tmo=%b required 000/000/0", sdram_req, m_ack, ack_timeout);
    end
    n_cmp++; if (sdram_addr !== 26'h0 || m_rdvalid !== 3'b000 || m_rdata !== 32'h0) begin
      n_bad++; $display("FAIL rb_clear: addr=%h rdvalid=%b rdata=%h required zeros", sdram_addr, m_rdvalid, m_rdata);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    sdram_ack = 1'b0; sdram_rdvalid = 3'b000;
    tick();
    n_cmp++; if (sdram_req !== 3'b001 || sdram_addr !== 26'h0000123) begin
      n_bad++; $display("FAIL rb_first: req=%b addr=%h required 001/0000123", sdram_req, sdram_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_req = 3'b000; m_write = 3'b000;
    for (int i = 0; i < 3; i++) begin addr_v[i] = '0; be_v[i] = '0; wd_v[i] = '0; end
    sdram_ack = 1'b0; sdram_rdata = '0; sdram_rdvalid = '0;
    model_reset();
    #2 reset = 1'b0;
    test_reset();
    test_single_read();
    test_write();
    test_alternate();
    test_prio();
    test_random();
    test_timeout();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
